// File: rtl/sim_exit_reporter_if.sv
// Write bus from the core plus the pass/fail status lines reported back to the test driver.
interface sim_exit_reporter_if;
  logic        io_wr_valid;
  logic        io_wr_ready;
  logic [31:0] io_wr_addr;
  logic [63:0] io_wr_data;
  logic [7:0]  io_wr_mask;
  logic        io_success;
  logic        io_failure;
  logic [62:0] io_exit_code;

  modport master (
    output io_wr_valid, io_wr_addr, io_wr_data, io_wr_mask,
    input  io_wr_ready, io_success, io_failure, io_exit_code
  );

  modport slave (
    input  io_wr_valid, io_wr_addr, io_wr_data, io_wr_mask,
    output io_wr_ready, io_success, io_failure, io_exit_code
  );
endinterface

// File: rtl/sim_exit_reporter.sv
// Watches tohost writes and a cycle watchdog, then latches a sticky pass/fail verdict.
// Verdict visible two cycles after the tohost accept; ready drops only in DECODE and during reset.
module sim_exit_reporter #(
  parameter logic [31:0] TOHOST_ADDR     = 32'h8000_1000,
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  sim_exit_reporter_if.slave    bus
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_PASS   = 2'd2;
  localparam logic [1:0] S_FAIL   = 2'd3;

  localparam logic [62:0] CODE_UNSUPPORTED = {63{1'b1}};
  localparam logic [62:0] CODE_WATCHDOG    = {{62{1'b1}}, 1'b0};

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [63:0] r_data;
  logic [31:0] r_wd_cnt;
  logic [62:0] r_code;
  logic [62:0] w_code_nxt;
  logic        w_accept;
  logic        w_tohost;
  logic        w_wd_fire;
  logic        w_unused_mask_hi;

  // Only the low word's strobes qualify a tohost write.
  assign w_unused_mask_hi = ^bus.io_wr_mask[7:4];

  assign bus.io_wr_ready = !reset && (r_state != S_DECODE);
  assign w_accept        = bus.io_wr_valid && bus.io_wr_ready;
  assign w_tohost        = w_accept && (r_state == S_RUN) &&
                           (bus.io_wr_addr == TOHOST_ADDR) &&
                           (bus.io_wr_mask[3:0] == 4'hF);

  // >= so a DECODE->RUN return past the limit still fires on the first idle RUN cycle.
  assign w_wd_fire = (WATCHDOG_CYCLES != 32'd0) && (r_state == S_RUN) &&
                     (r_wd_cnt >= WATCHDOG_CYCLES) && !w_tohost;

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    case (r_state)
      S_RUN: begin
        if (w_tohost) begin
          w_state_nxt = S_DECODE;
        end else if (w_wd_fire) begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = CODE_WATCHDOG;
        end
      end
      S_DECODE: begin
        if (r_data == 64'd0) begin
          w_state_nxt = S_RUN;
        end else if (r_data == 64'd1) begin
          w_state_nxt = S_PASS;
        end else if (r_data[0]) begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = r_data[63:1];
        end else begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = CODE_UNSUPPORTED;
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_data   <= 64'd0;
      r_wd_cnt <= 32'd0;
      r_code   <= 63'd0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      if (w_tohost) begin
        r_data <= bus.io_wr_data;
      end
      if (((r_state == S_RUN) || (r_state == S_DECODE)) && (r_wd_cnt != 32'hFFFF_FFFF)) begin
        r_wd_cnt <= r_wd_cnt + 32'd1;
      end
    end
  end

  assign bus.io_success   = (r_state == S_PASS);
  assign bus.io_failure   = (r_state == S_FAIL);
  assign bus.io_exit_code = (r_state == S_FAIL) ? r_code : 63'd0;

endmodule

// File: doc/sim_exit_reporter.md
SIM_EXIT_REPORTER -- requirements
Module: sim_exit_reporter

Interface
REQ-001 The block SHALL have parameter TOHOST_ADDR, default 32'h8000_1000, the byte address of the tohost word.
REQ-002 The block SHALL have parameter WATCHDOG_CYCLES, default 0, the cycle limit after reset (0 = watchdog disabled), 32-bit unsigned.
REQ-003 The block SHALL have port clock  input  1  the single clock; all logic on posedge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port io_wr_valid  input  1  write request valid.
REQ-006 The block SHALL have port io_wr_ready  output  1  write request accepted when valid&&ready.
REQ-007 The block SHALL have port io_wr_addr  input  32  byte address, 8-byte aligned.
REQ-008 The block SHALL have port io_wr_data  input  64  write data.
REQ-009 The block SHALL have port io_wr_mask  input  8  byte strobes, bit i covers data[8i+7:8i].
REQ-010 The block SHALL have port io_success  output  1  sticky pass indication to the test driver.
REQ-011 The block SHALL have port io_failure  output  1  sticky fail indication.
REQ-012 The block SHALL have port io_exit_code  output  63  fail code, valid while io_failure=1.

Function
REQ-013 The FSM SHALL have states RUN, DECODE, PASS, FAIL.
REQ-014 In RUN, io_wr_ready SHALL be 1, and each accepted write SHALL complete in one cycle with no backpressure.
REQ-015 In RUN, an accepted write with addr==TOHOST_ADDR and mask[3:0]==4'hF SHALL latch io_wr_data into a 64-bit register and move to DECODE on the next cycle.
REQ-016 Accepted writes to other addresses, and tohost writes with mask[3:0]!=4'hF, SHALL be discarded with no state change.
REQ-017 In DECODE (exactly 1 cycle), io_wr_ready SHALL be 0.
REQ-018 In DECODE, a latched value of 0 SHALL return the FSM to RUN.
REQ-019 In DECODE, a latched value of 1 SHALL move the FSM to PASS.
REQ-020 In DECODE, a value with bit0=1 and value!=1 SHALL move the FSM to FAIL with exit_code=value[63:1].
REQ-021 In DECODE, a nonzero value with bit0=0 (unsupported syscall) SHALL move the FSM to FAIL with exit_code=all-ones.
REQ-022 Latency: for a tohost write accepted in cycle N, io_success/io_failure SHALL be 1 from cycle N+2.
REQ-023 PASS and FAIL SHALL be terminal until reset: io_wr_ready=1, all writes sunk and ignored, outputs held.
REQ-024 io_success SHALL be 1 only in PASS, and io_failure 1 only in FAIL; the two SHALL never both be 1.
REQ-025 Watchdog: a 32-bit counter SHALL increment every cycle in RUN or DECODE, saturating at all-ones, and SHALL be frozen in PASS/FAIL.
REQ-026 If WATCHDOG_CYCLES!=0 and counter==WATCHDOG_CYCLES while in RUN with no tohost write accepted that cycle, the next state SHALL be FAIL with exit_code=all-ones minus 1.
REQ-027 Simultaneous watchdog expiry and tohost accept SHALL give the write priority, via DECODE.
REQ-028 The watchdog SHALL NOT fire from DECODE; if DECODE returns to RUN past the limit, it SHALL fire on the first RUN cycle with no tohost accept.
REQ-029 io_exit_code SHALL be 0 in RUN, DECODE and PASS.

Reset
REQ-030 With reset=1 at a posedge, the next cycle SHALL have state=RUN, counter=0, data register=0, io_success=0, io_failure=0, io_exit_code=0.
REQ-031 During reset, io_wr_ready SHALL be 0, and writes presented SHALL be ignored.
REQ-032 Reset asserted in any state, including mid-DECODE or PASS/FAIL, SHALL discard the pending decode and restore REQ-030 values.

Verification
REQ-033 The bench SHALL cover: write TOHOST_ADDR data=1 mask=FF in cycle N -> io_success=1 from N+2, io_failure=0, io_exit_code=0, held 100 cycles.
REQ-034 The bench SHALL cover: write data=0x7 (code 3) -> io_failure=1, io_exit_code=3; a later write of data=1 -> no change.
REQ-035 The bench SHALL cover: writes to TOHOST_ADDR+8 data=1, TOHOST_ADDR mask=0xF0 data=1, then TOHOST_ADDR data=0 -> io_success=0, io_failure=0, ready=1 except the DECODE cycle.
REQ-036 The bench SHALL cover: write data=0x2 -> io_failure=1, io_exit_code=63'h7FFF_FFFF_FFFF_FFFF.
REQ-037 The bench SHALL cover: WATCHDOG_CYCLES=50, no writes -> io_failure=1, code=63'h7FFF_FFFF_FFFF_FFFE; and a tohost data=1 accepted in the expiry cycle -> io_success=1 instead.
REQ-038 The bench SHALL cover: reset pulsed 1 cycle during DECODE and again in FAIL -> all outputs 0, counter restarted, then a data=1 write -> pass at N+2.
